// File: rtl/hv_pkg.sv
// HDC job sequencer shared definitions.
// State encoding and default widths for the sequencer and its counters.
package hv_pkg;

    localparam int N_CORES    = 32;
    localparam int ITEM_W_DEF = 16;
    localparam int CNT_W_DEF  = 20;
    localparam int REM_W_DEF  = $clog2(N_CORES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GEN,
        S_RUN,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/hv_window_cnt.sv
// Nested beat (j) / window (i) counter for the stream-consume phase.
// Flags the beat closing a window and the beat closing the whole job.
module hv_window_cnt
    import hv_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             beat,
    input  logic [CNT_W-1:0] ngram,
    input  logic [CNT_W-1:0] groups,
    output logic             win_end,
    output logic             job_end
);

    logic [CNT_W-1:0] j_q;
    logic [CNT_W-1:0] i_q;

    assign win_end = beat && (j_q == ngram);
    assign job_end = win_end && (i_q == groups);

    // j wraps at ngram and carries into i; i wraps after the final window
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            j_q <= '0;
            i_q <= '0;
        end else if (beat) begin
            if (win_end) begin
                j_q <= '0;
                i_q <= job_end ? '0 : i_q + 1'b1;
            end else begin
                j_q <= j_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hv_job_sequencer.sv
// HDC encoding job sequencer: item-memory gen, stream run, result drain.
// Latches job config, throttles the input stream, emits datapath pulses.
module hv_job_sequencer
    import hv_pkg::*;
#(
    parameter int ITEM_W = ITEM_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int REM_W  = REM_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [ITEM_W-1:0] cfg_item_num,
    input  logic [CNT_W-1:0]  cfg_ngram,
    input  logic [CNT_W-1:0]  cfg_groups,
    input  logic [REM_W-1:0]  cfg_remainder,
    input  logic              get_valid,
    output logic              get_ready,
    output logic              get_v,
    input  logic              stream_done,
    output logic              gen,
    output logic              run,
    output logic [ITEM_W-1:0] item_a,
    output logic              exec,
    output logic              update,
    output logic              last_update,
    output logic              get_fin,
    output logic [REM_W-1:0]  remainder_q,
    output logic              busy,
    output logic              done,
    output logic              aborted
);

    state_t state_q;
    state_t state_d;

    logic [ITEM_W-1:0] item_num_q;
    logic [CNT_W-1:0]  ngram_q;
    logic [CNT_W-1:0]  groups_q;

    logic start_ok;
    logic abort_ok;
    logic gen_last;
    logic win_end;
    logic job_end;

    assign get_ready = (state_q == S_RUN);
    assign get_v     = get_valid && get_ready;
    assign gen       = (state_q == S_GEN);
    assign run       = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign busy      = (state_q != S_IDLE);

    hv_window_cnt #(
        .CNT_W(CNT_W)
    ) u_win (
        .clk    (clk),
        .rst    (rst),
        .clr    (start_ok || abort_ok),
        .beat   (get_v),
        .ngram  (ngram_q),
        .groups (groups_q),
        .win_end(win_end),
        .job_end(job_end)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; abort overrides everything outside IDLE
    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        abort_ok = 1'b0;
        gen_last = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (cfg_start && !cfg_abort) begin
                    start_ok = 1'b1;
                    state_d  = S_GEN;
                end
            end
            S_GEN: begin
                gen_last = (item_a == item_num_q);
                if (gen_last) state_d = S_RUN;
            end
            S_RUN: begin
                if (job_end) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (stream_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (cfg_abort && (state_q != S_IDLE)) begin
            abort_ok = 1'b1;
            state_d  = S_IDLE;
        end
    end

    // Config latches, item address, sticky flags and datapath pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            item_num_q  <= '0;
            ngram_q     <= '0;
            groups_q    <= '0;
            remainder_q <= '0;
            item_a      <= '0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            exec        <= 1'b0;
            update      <= 1'b0;
            last_update <= 1'b0;
            get_fin     <= 1'b0;
        end else begin
            if (start_ok) begin
                item_num_q  <= cfg_item_num;
                ngram_q     <= cfg_ngram;
                groups_q    <= cfg_groups;
                remainder_q <= cfg_remainder;
                done        <= 1'b0;
                aborted     <= 1'b0;
            end
            if (abort_ok) begin
                aborted <= 1'b1;
            end else if ((state_q == S_DRAIN) && stream_done) begin
                done <= 1'b1;
            end
            if (gen && !gen_last && !abort_ok) begin
                item_a <= item_a + 1'b1;
            end else begin
                item_a <= '0;
            end
            exec        <= get_v && !abort_ok;
            update      <= win_end && !abort_ok;
            last_update <= job_end && !abort_ok;
            get_fin     <= last_update && !abort_ok;
        end
    end

endmodule

// File: tb/tb_hv_job_sequencer.sv
// Self-checking bench for hv_job_sequencer.
// Vector table for the basic job, scoreboard-driven job runner for the rest.
module tb_hv_job_sequencer;

    localparam int ITEM_W = 16;
    localparam int CNT_W  = 20;
    localparam int REM_W  = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_start = 1'b0;
    logic              cfg_abort = 1'b0;
    logic [ITEM_W-1:0] cfg_item_num = '0;
    logic [CNT_W-1:0]  cfg_ngram = '0;
    logic [CNT_W-1:0]  cfg_groups = '0;
    logic [REM_W-1:0]  cfg_remainder = '0;
    logic              get_valid = 1'b0;
    logic              get_ready;
    logic              get_v;
    logic              stream_done = 1'b0;
    logic              gen;
    logic              run;
    logic [ITEM_W-1:0] item_a;
    logic              exec;
    logic              update;
    logic              last_update;
    logic              get_fin;
    logic [REM_W-1:0]  remainder_q;
    logic              busy;
    logic              done;
    logic              aborted;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hv_job_sequencer #(
        .ITEM_W(ITEM_W),
        .CNT_W (CNT_W),
        .REM_W (REM_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_start    (cfg_start),
        .cfg_abort    (cfg_abort),
        .cfg_item_num (cfg_item_num),
        .cfg_ngram    (cfg_ngram),
        .cfg_groups   (cfg_groups),
        .cfg_remainder(cfg_remainder),
        .get_valid    (get_valid),
        .get_ready    (get_ready),
        .get_v        (get_v),
        .stream_done  (stream_done),
        .gen          (gen),
        .run          (run),
        .item_a       (item_a),
        .exec         (exec),
        .update       (update),
        .last_update  (last_update),
        .get_fin      (get_fin),
        .remainder_q  (remainder_q),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted)
    );

    typedef struct {
        bit st;
        bit sd;
        bit gen;
        bit run;
        int ia;
        bit ex;
        bit up;
        bit lu;
        bit gf;
        bit rdy;
        bit bsy;
        bit dn;
    } vec_t;

    typedef struct {
        bit ex;
        bit up;
        bit lu;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 valid always high, 1 alternating, 2 random
    task automatic run_job(input int itm, input int ng, input int gr,
                           input int rem, input int mode,
                           input int abort_at, input bit alt_start);
        int   j = 0;
        int   i = 0;
        int   beats = 0;
        int   n_exec = 0;
        int   cyc = 0;
        bit   fin = 0;
        bit   prev_lu = 0;
        bit   v;
        bit   up;
        bit   lu;
        exp_t e;
        cfg_item_num  = ITEM_W'(itm);
        cfg_ngram     = CNT_W'(ng);
        cfg_groups    = CNT_W'(gr);
        cfg_remainder = REM_W'(rem);
        get_valid     = 1'b0;
        cfg_start     = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_done_clr", done, 0);
        chk("start_abort_clr", aborted, 0);
        chk("start_rem", remainder_q, rem);
        for (int k = 0; k <= itm; k++) begin
            chk("gen_hi", gen, 1);
            chk("gen_item_a", item_a, k);
            tick();
        end
        chk("run_gen_lo", gen, 0);
        chk("run_hi", run, 1);
        chk("run_ready", get_ready, 1);
        chk("run_item_a", item_a, 0);
        while (!fin && cyc < 400) begin
            cyc++;
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 1;
                default: v = 1'($urandom_range(0, 1));
            endcase
            get_valid = v;
            if (abort_at >= 0 && beats == abort_at) begin
                cfg_abort = 1'b1;
                tick();
                cfg_abort = 1'b0;
                get_valid = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_flag", aborted, 1);
                chk("abort_run", run, 0);
                chk("abort_ready", get_ready, 0);
                chk("abort_exec", exec, 0);
                sb.delete();
                return;
            end
            if (alt_start && beats == 1) begin
                cfg_start     = 1'b1;
                cfg_item_num  = ITEM_W'(itm + 5);
                cfg_ngram     = CNT_W'(ng + 3);
                cfg_groups    = CNT_W'(gr + 2);
                cfg_remainder = REM_W'(rem + 1);
            end
            #1;
            chk("run_get_v", get_v, v);
            if (v) begin
                up = (j == ng);
                lu = up && (i == gr);
                sb.push_back('{1'b1, up, lu});
                if (up) begin
                    j = 0;
                    i++;
                end else begin
                    j++;
                end
                beats++;
                fin = lu;
            end else begin
                sb.push_back('{1'b0, 1'b0, 1'b0});
            end
            tick();
            cfg_start = 1'b0;
            e = sb.pop_front();
            chk("sb_exec", exec, e.ex);
            chk("sb_update", update, e.up);
            chk("sb_last", last_update, e.lu);
            chk("sb_fin_prev", get_fin, prev_lu);
            if (exec) n_exec++;
            prev_lu = e.lu;
        end
        chk("run_bound", fin, 1);
        get_valid = 1'b1;
        #1;
        chk("drain_ready", get_ready, 0);
        chk("drain_get_v", get_v, 0);
        chk("drain_run", run, 1);
        tick();
        chk("drain_fin", get_fin, 1);
        chk("drain_exec", exec, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("drain_hold_exec", exec, 0);
            chk("drain_hold_busy", busy, 1);
        end
        get_valid = 1'b0;
        chk("exec_total", n_exec, (ng + 1) * (gr + 1));
        chk("rem_kept", remainder_q, rem);
        stream_done = 1'b1;
        tick();
        stream_done = 1'b0;
        chk("done_set", done, 1);
        chk("done_busy", busy, 0);
        chk("done_run", run, 0);
    endtask

    vec_t tv[13];

    initial begin
        tv[0]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        tv[1]  = '{0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0};
        tv[2]  = '{0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 1, 0};
        tv[3]  = '{0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 1, 0};
        tv[4]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0};
        tv[5]  = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0};
        tv[6]  = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0};
        tv[7]  = '{0, 0, 0, 1, 0, 1, 1, 0, 0, 1, 1, 0};
        tv[8]  = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0};
        tv[9]  = '{0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 0};
        tv[10] = '{0, 0, 0, 1, 0, 1, 1, 1, 0, 0, 1, 0};
        tv[11] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0};
        tv[12] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_gen", gen, 0);
        chk("rst_run", run, 0);
        chk("rst_ready", get_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_item_a", item_a, 0);

        // T1/T3: basic job from the vector table
        cfg_item_num  = 3;
        cfg_ngram     = 2;
        cfg_groups    = 1;
        cfg_remainder = 9;
        get_valid     = 1'b1;
        for (int r = 0; r < 13; r++) begin
            cfg_start   = tv[r].st;
            stream_done = tv[r].sd;
            tick();
            chk($sformatf("t1_gen[%0d]", r), gen, tv[r].gen);
            chk($sformatf("t1_run[%0d]", r), run, tv[r].run);
            chk($sformatf("t1_item_a[%0d]", r), item_a, tv[r].ia);
            chk($sformatf("t1_exec[%0d]", r), exec, tv[r].ex);
            chk($sformatf("t1_update[%0d]", r), update, tv[r].up);
            chk($sformatf("t1_last[%0d]", r), last_update, tv[r].lu);
            chk($sformatf("t1_fin[%0d]", r), get_fin, tv[r].gf);
            chk($sformatf("t1_ready[%0d]", r), get_ready, tv[r].rdy);
            chk($sformatf("t1_busy[%0d]", r), busy, tv[r].bsy);
            chk($sformatf("t1_done[%0d]", r), done, tv[r].dn);
        end
        cfg_start   = 1'b0;
        stream_done = 1'b0;
        get_valid   = 1'b0;
        chk("t1_rem", remainder_q, 9);

        // T2: toggling valid; start also clears the previous done
        run_job(3, 2, 1, 4, 1, -1, 0);
        // random throttling over a larger job
        run_job(2, 3, 2, 17, 2, -1, 0);
        // T4: abort after two beats, then a clean restart
        run_job(3, 2, 1, 5, 0, 2, 0);
        run_job(3, 2, 1, 6, 0, -1, 0);
        // T5: start with altered config during RUN is ignored
        run_job(1, 2, 1, 3, 0, -1, 1);
        // ngram=0: every beat is an update
        run_job(0, 0, 3, 1, 2, -1, 0);

        // abort during GEN
        cfg_item_num = 5;
        cfg_start    = 1'b1;
        tick();
        cfg_start = 1'b0;
        tick();
        chk("gabort_item_a_pre", item_a, 1);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("gabort_busy", busy, 0);
        chk("gabort_gen", gen, 0);
        chk("gabort_item_a", item_a, 0);
        chk("gabort_flag", aborted, 1);

        // T6: minimal job, reset while draining
        cfg_item_num  = 0;
        cfg_ngram     = 0;
        cfg_groups    = 0;
        cfg_remainder = 7;
        cfg_start     = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("t6_gen", gen, 1);
        chk("t6_item_a", item_a, 0);
        tick();
        chk("t6_gen_lo", gen, 0);
        chk("t6_ready", get_ready, 1);
        get_valid = 1'b1;
        tick();
        get_valid = 1'b0;
        chk("t6_exec", exec, 1);
        chk("t6_update", update, 1);
        chk("t6_last", last_update, 1);
        chk("t6_drain_ready", get_ready, 0);
        chk("t6_rem", remainder_q, 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6r_busy", busy, 0);
        chk("t6r_run", run, 0);
        chk("t6r_fin", get_fin, 0);
        chk("t6r_exec", exec, 0);
        chk("t6r_update", update, 0);
        chk("t6r_last", last_update, 0);
        chk("t6r_rem", remainder_q, 0);
        chk("t6r_done", done, 0);
        chk("t6r_aborted", aborted, 0);

        // abort+start together in IDLE: start dropped
        cfg_start = 1'b1;
        cfg_abort = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        chk("both_busy", busy, 0);
        chk("both_aborted", aborted, 0);
        // stream_done in IDLE is ignored
        stream_done = 1'b1;
        tick();
        stream_done = 1'b0;
        chk("idle_sd_done", done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
